// File: rtl/jesd_link_bringup_sequencer.sv
// JESD204 RX link bring-up sequencer: issues reset requests, waits out the reset pulse, then waits for SYNC/valid data.
// Optional macro JESD_SEQ_AXI_RESET_EN splits the master reset into separate AXI and RX reset requests.
module jesd_link_bringup_sequencer #(
    parameter int PULSE_LEN     = 4800,
    parameter int RST_MARGIN    = 16,
    parameter int SYNC_TIMEOUT  = 1000000,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       m_axi_aclk,
    input  logic       m_axi_aresetn,
    input  logic       start,
    input  logic       rx_sync,
    input  logic       rx_tvalid,
    output logic       master_reset,
    output logic       rx_reset,
    output logic       axi_reset,
    output logic       link_up,
    output logic       link_fail,
    output logic       busy,
    output logic [3:0] retry_count,
    output logic [2:0] state
);

    localparam int WAIT_LEN = PULSE_LEN + RST_MARGIN;
    localparam int WAIT_W   = $clog2(WAIT_LEN + 1);
    localparam int TO_W     = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
    localparam int STB_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_LEN);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(SYNC_TIMEOUT - 1);
    localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRIES);

    // Handshake: start is a level sampled once per cycle; reset requests are single-cycle strobes
    // with no back-pressure, the pulse generator is expected to accept every strobe.
    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
`ifdef JESD_SEQ_AXI_RESET_EN
        S_RST_AXI     = 3'd1,
`else
        S_RST_ALL     = 3'd1,
`endif
        S_RST_RX      = 3'd2,
        S_WAIT_RST    = 3'd3,
        S_WAIT_SYNC   = 3'd4,
        S_WAIT_STABLE = 3'd5,
        S_LINK_UP     = 3'd6,
        S_FAIL        = 3'd7
    } state_t;

`ifdef JESD_SEQ_AXI_RESET_EN
    localparam state_t S_FIRST = S_RST_AXI;
`else
    localparam state_t S_FIRST = S_RST_ALL;
`endif

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [STB_W-1:0]  stb_q, stb_d;
    logic [3:0]        retry_q, retry_d;
    logic              link_lost;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        to_d      = to_q;
        stb_d     = stb_q;
        retry_d   = retry_q;
        link_lost = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FIRST;
                    retry_d = '0;
                end
            end
`ifdef JESD_SEQ_AXI_RESET_EN
            S_RST_AXI: begin
                state_d = S_RST_RX;
            end
`else
            S_RST_ALL: begin
                state_d = S_WAIT_RST;
                wait_d  = WAIT_LOAD;
            end
`endif
            S_RST_RX: begin
                state_d = S_WAIT_RST;
                wait_d  = WAIT_LOAD;
            end
            S_WAIT_RST: begin
                if (wait_q == WAIT_ONE) begin
                    state_d = S_WAIT_SYNC;
                    to_d    = '0;
                end else begin
                    wait_d = wait_q - WAIT_ONE;
                end
            end
            S_WAIT_SYNC: begin
                // A sync arriving on the timeout cycle takes priority over the retry.
                if (rx_sync) begin
                    state_d = S_WAIT_STABLE;
                    stb_d   = '0;
                end else if (to_q == TO_LAST) begin
                    link_lost = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_WAIT_STABLE: begin
                if (!rx_sync) begin
                    state_d = S_WAIT_SYNC;
                    to_d    = '0;
                end else if (rx_tvalid) begin
                    if (stb_q == STB_LAST) begin
                        state_d = S_LINK_UP;
                    end else begin
                        stb_d = stb_q + 1'b1;
                    end
                end else begin
                    stb_d = '0;
                end
            end
            S_LINK_UP: begin
                if (start) begin
                    state_d = S_FIRST;
                    retry_d = '0;
                end else if (!rx_sync) begin
                    link_lost = 1'b1;
                end
            end
            S_FAIL: begin
                if (start) begin
                    state_d = S_FIRST;
                    retry_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (link_lost) begin
            if (retry_q < RETRY_MAX) begin
                state_d = S_RST_RX;
                retry_d = retry_q + 1'b1;
            end else begin
                state_d = S_FAIL;
            end
        end
    end

    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            to_q      <= '0;
            stb_q     <= '0;
            retry_q   <= '0;
            rx_reset  <= 1'b0;
            link_up   <= 1'b0;
            link_fail <= 1'b0;
            busy      <= 1'b0;
`ifdef JESD_SEQ_AXI_RESET_EN
            axi_reset <= 1'b0;
`else
            master_reset <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            to_q      <= to_d;
            stb_q     <= stb_d;
            retry_q   <= retry_d;
            rx_reset  <= (state_d == S_RST_RX);
            link_up   <= (state_d == S_LINK_UP);
            link_fail <= (state_d == S_FAIL);
            busy      <= !((state_d == S_IDLE) || (state_d == S_LINK_UP) || (state_d == S_FAIL));
`ifdef JESD_SEQ_AXI_RESET_EN
            axi_reset <= (state_d == S_RST_AXI);
`else
            master_reset <= (state_d == S_RST_ALL);
`endif
        end
    end

`ifdef JESD_SEQ_AXI_RESET_EN
    assign master_reset = 1'b0;
`else
    assign axi_reset = 1'b0;
`endif

    assign state       = state_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_jesd_link_bringup_sequencer.sv
// Bench for jesd_link_bringup_sequencer: directed bring-up scenarios plus random stimulus against a timestamp-based model.
module tb_jesd_link_bringup_sequencer;
    localparam int PULSE_LEN     = 8;
    localparam int RST_MARGIN    = 2;
    localparam int SYNC_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 4;
    localparam int MAX_RETRIES   = 2;
    localparam int NWAIT         = PULSE_LEN + RST_MARGIN;
    localparam int W             = 13;
`ifdef JESD_SEQ_AXI_RESET_EN
    localparam int AXI_EN = 1;
`else
    localparam int AXI_EN = 0;
`endif
    localparam int D = AXI_EN;

    logic       m_axi_aclk    = 1'b0;
    logic       m_axi_aresetn = 1'b0;
    logic       start         = 1'b0;
    logic       rx_sync       = 1'b0;
    logic       rx_tvalid     = 1'b0;
    logic       master_reset, rx_reset, axi_reset, link_up, link_fail, busy;
    logic [3:0] retry_count;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;
    int rc    = 0;
    logic [W-1:0] exp_q[$];

    jesd_link_bringup_sequencer #(
        .PULSE_LEN(PULSE_LEN), .RST_MARGIN(RST_MARGIN), .SYNC_TIMEOUT(SYNC_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES), .MAX_RETRIES(MAX_RETRIES)
    ) dut (
        .m_axi_aclk(m_axi_aclk), .m_axi_aresetn(m_axi_aresetn), .start(start),
        .rx_sync(rx_sync), .rx_tvalid(rx_tvalid), .master_reset(master_reset),
        .rx_reset(rx_reset), .axi_reset(axi_reset), .link_up(link_up),
        .link_fail(link_fail), .busy(busy), .retry_count(retry_count), .state(state)
    );

    // clock / reset
    always #5 m_axi_aclk = ~m_axi_aclk;

    // reference model: state code, time of state entry and last bad data cycle
    int ms = 0, mr = 0, m_enter = 0, m_last_bad = 0, cyc = 0, nxt = 0, age = 0;
    bit lost;

    function automatic logic [W-1:0] pack_exp(input int s, input int r);
        logic [2:0] s3;
        logic [3:0] r4;
        s3 = s[2:0];
        r4 = r[3:0];
        return {s3, r4, (AXI_EN == 0) && (s == 1), (s == 2), (AXI_EN == 1) && (s == 1),
                (s == 6), (s == 7), !((s == 0) || (s == 6) || (s == 7))};
    endfunction

    always @(posedge m_axi_aclk) begin
        nxt  = ms;
        lost = 1'b0;
        if (!m_axi_aresetn) begin
            nxt = 0;
            mr  = 0;
        end else begin
            age = cyc - m_enter + 1;
            if (((ms == 0) || (ms == 6) || (ms == 7)) && start) begin
                nxt = 1;
                mr  = 0;
            end else begin
                case (ms)
                    1: nxt = (AXI_EN != 0) ? 2 : 3;
                    2: nxt = 3;
                    3: if (age >= NWAIT) nxt = 4;
                    4: begin
                        if (rx_sync) nxt = 5;
                        else if (age >= SYNC_TIMEOUT) lost = 1'b1;
                    end
                    5: begin
                        if (!rx_sync) nxt = 4;
                        else begin
                            if (!rx_tvalid) m_last_bad = cyc;
                            if (cyc - m_last_bad >= STABLE_CYCLES) nxt = 6;
                        end
                    end
                    6: if (!rx_sync) lost = 1'b1;
                    default: ;
                endcase
                if (lost) begin
                    if (mr < MAX_RETRIES) begin
                        nxt = 2;
                        mr  = mr + 1;
                    end else begin
                        nxt = 7;
                    end
                end
            end
        end
        if (nxt != ms) begin
            m_enter = cyc + 1;
            if (nxt == 5) m_last_bad = cyc;
        end
        ms = nxt;
        exp_q.push_back(pack_exp(ms, mr));
        cyc = cyc + 1;
    end

    // scoreboard: every cycle after an edge, DUT outputs against the model
    logic [W-1:0] sb_exp, sb_act;
    always @(negedge m_axi_aclk) begin
        if (exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            sb_act = {state, retry_count, master_reset, rx_reset, axi_reset, link_up, link_fail, busy};
            n_cmp  = n_cmp + 1;
            if (sb_act !== sb_exp) begin
                n_err = n_err + 1;
                $display("FAIL model_cmp cyc=%0d actual=%b required=%b", cyc, sb_act, sb_exp);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge m_axi_aclk);
        @(negedge m_axi_aclk);
        rc = rc + 1;
    endtask

    task automatic go_to(input int c);
        while (rc < c) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s actual=%0h required=%0h rc=%0d", name, got, exp, rc);
        end
    endtask

    task automatic chk_first_pulse(input string name);
        chk(name, {29'd0, master_reset, rx_reset, axi_reset}, (AXI_EN != 0) ? 32'b001 : 32'b100);
    endtask

    logic pulses;

    initial begin
        repeat (3) @(negedge m_axi_aclk);
        chk("reset_state", {26'd0, state, master_reset, rx_reset, link_up, link_fail, busy, axi_reset}, 32'd0);

        // 1: plain bring-up
        m_axi_aresetn = 1'b1;
        rc = 0;
        pulse_start();
        chk_first_pulse("s1_first_pulse");
        chk("s1_state1", {29'd0, state}, 32'd1);
        step();
        chk("s1_second", {29'd0, master_reset, rx_reset, axi_reset}, (AXI_EN != 0) ? 32'b010 : 32'b000);
        go_to(5);
        rx_sync   = 1'b1;
        rx_tvalid = 1'b1;
        go_to(11 + D);
        chk("s1_wait_rst", {29'd0, state}, 32'd3);
        step();
        chk("s1_wait_sync", {29'd0, state}, 32'd4);
        go_to(16 + D);
        chk("s1_not_up", {31'd0, link_up}, 32'd0);
        step();
        chk("s1_link_up", {27'd0, link_up, busy, retry_count}, 32'b10_0000);

        // 3: break a stable run with rx_tvalid
        rc = 0;
        pulse_start();
        go_to(15 + D);
        rx_tvalid = 1'b0;
        step();
        rx_tvalid = 1'b1;
        chk("s3_still_stable", {29'd0, state}, 32'd5);
        go_to(19 + D);
        chk("s3_not_up", {31'd0, link_up}, 32'd0);
        step();
        chk("s3_link_up", {31'd0, link_up}, 32'd1);

        // 4: one-cycle loss of sync in LINK_UP
        rc = 0;
        rx_sync = 1'b0;
        step();
        rx_sync = 1'b1;
        chk("s4_rx_pulse", {26'd0, rx_reset, link_up, retry_count}, 32'b10_0001);
        step();
        chk("s4_rx_single", {31'd0, rx_reset}, 32'd0);
        go_to(16);
        chk("s4_not_up", {31'd0, link_up}, 32'd0);
        step();
        chk("s4_relink", {27'd0, link_up, retry_count}, 32'b1_0001);

        // 2: start together with sync loss, then timeouts to FAIL
        rc = 0;
        rx_sync   = 1'b0;
        rx_tvalid = 1'b0;
        pulse_start();
        chk_first_pulse("s2_start_wins");
        chk("s2_retry0", {28'd0, retry_count}, 32'd0);
        go_to(31 + D);
        chk("s2_sync_wait1", {29'd0, state}, 32'd4);
        step();
        chk("s2_retry1", {27'd0, rx_reset, retry_count}, 32'b1_0001);
        step();
        chk("s2_retry1_end", {31'd0, rx_reset}, 32'd0);
        go_to(62 + D);
        chk("s2_sync_wait2", {29'd0, state}, 32'd4);
        step();
        chk("s2_retry2", {27'd0, rx_reset, retry_count}, 32'b1_0010);
        go_to(93 + D);
        chk("s2_sync_wait3", {29'd0, state}, 32'd4);
        step();
        chk("s2_fail", {26'd0, link_fail, busy, retry_count}, 32'b10_0010);
        go_to(100);
        pulse_start();
        chk_first_pulse("s2_restart");
        chk("s2_restart_retry", {28'd0, retry_count}, 32'd0);

        // 5: reset during WAIT_RST
        go_to(105);
        m_axi_aresetn = 1'b0;
        step();
        chk("s5_reset", {23'd0, state, retry_count, master_reset, rx_reset, axi_reset, link_up, link_fail, busy}, 32'd0);
        m_axi_aresetn = 1'b1;
        pulses = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            pulses = pulses | master_reset | rx_reset | axi_reset;
        end
        chk("s5_no_pulse", {31'd0, pulses}, 32'd0);
        chk("s5_idle", {29'd0, state}, 32'd0);

        // random stimulus, checked by the scoreboard every cycle
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 29) == 0) rx_sync = ~rx_sync;
            if ($urandom_range(0, 7) == 0) rx_tvalid = ~rx_tvalid;
            m_axi_aresetn = ($urandom_range(0, 599) != 0);
            step();
        end
        start = 1'b0;
        m_axi_aresetn = 1'b1;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
